jtdsp16_do_cache: RTL and testbench
===================================

# jtdsp16_do_cache

DO-loop instruction cache for the JTDSP16 core. It sits on the instruction path between program ROM and the instruction decoder. It captures the first pass of a `do K { NI instructions }` body as it is fetched from ROM. It then replays the body from an internal 15×16 store for the remaining K−1 passes, holding the program counter while it does so. It consumes the decoder's `do_start`/`do_data` pair, and its `cache_dout` feeds the decoder's instruction input through the X-bus mux.

## Interface
Parameters:
- none (depth fixed at 15 words, NI field is 4 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  instruction-rate clock enable; all state advances only when cen=1
- fetch  in  1  decoder accepts a new instruction word this cen cycle (low on the 2nd cycle of double-cycle instructions)
- do_start  in  1  DO/REDO instruction decoded
- do_data  in  11  [10:7]=NI (0 = redo), [6:0]=K
- rom_dout  in  16  instruction word from program ROM
- cache_dout  out  16  replayed instruction word, cache[rd_ptr]
- cache_sel  out  1  decoder/X-bus must take cache_dout instead of rom_dout
- pc_hold  out  1  ROM PC must not advance
- no_int  out  1  interrupts blocked (high whenever state≠IDLE)
- do_err  out  1  one-cen-cycle pulse on an illegal request
- loop_cnt  out  7  remaining passes, including the current one (debug)

## Operation
- State register: IDLE, FILL, REPLAY. Also held: ni (4b), last_ni (4b), wr_ptr/rd_ptr (4b), iter (7b), and a 15×16 store.
- Effective K: keff = (K<2) ? 1 : K. K=0 and K=1 both mean a single pass.
- IDLE, cen & do_start, NI≠0:
  - ni←NI, last_ni←NI, wr_ptr←0, iter←keff, go FILL.
- IDLE, cen & do_start, NI=0 (redo, see Configuration):
  - If last_ni≠0: ni←last_ni, rd_ptr←0, iter←keff, go REPLAY. cache_sel and pc_hold are registered high.
  - If last_ni=0: pulse do_err and stay IDLE.
- FILL, cen & fetch:
  - store[wr_ptr]←rom_dout, wr_ptr++.
  - When wr_ptr==ni−1: if iter≥2, then iter←iter−1, rd_ptr←0, go REPLAY, and set cache_sel=pc_hold=1. Otherwise go IDLE.
- REPLAY, cen & fetch:
  - rd_ptr++.
  - When rd_ptr==ni−1: rd_ptr←0. If iter==1, go IDLE and clear cache_sel and pc_hold. Otherwise iter←iter−1.
- do_start while state≠IDLE (nesting): ignored; do_err pulses; loop continues unaffected.
- fetch=0 cycles (double-cycle instructions, pc_halt stalls): no pointer or counter movement.
- The store is written only in FILL. Its contents and last_ni survive loop end, so a later redo can use them.

## Timing
- Reset values: state=IDLE, cache_sel=0, pc_hold=0, no_int=0, do_err=0, loop_cnt=0, last_ni=0, pointers 0. Store contents are don't-care.
- Reset mid-loop returns to IDLE immediately. A subsequent redo then reports do_err.
- cache_sel, pc_hold, no_int and do_err are registered. cache_dout is a combinational read of the store at the registered rd_ptr, valid in the same cycle as cache_sel.
- The first fill word is the first fetch after the cen cycle that samples do_start.
- The first replay word is presented on the fetch after the last fill word, or for redo, the fetch after do_start. There is no bubble.
- Total instructions issued = ni×keff, in order.
- NI=1: every replay fetch wraps rd_ptr at 0.
- iter decrements once per completed pass. loop_cnt = iter.

## Configuration
- JTDSP16_REDO_EN defined: NI=0 performs redo as described.
- JTDSP16_REDO_EN undefined: NI=0 with do_start is illegal; do_err pulses and state stays IDLE. last_ni logic may be removed.

## Test plan
- do NI=3,K=4 with ROM words A,B,C: decoder sees A,B,C from ROM, then A,B,C ×3 from cache. pc_hold is high for exactly 9 fetches. no_int is high for 12 fetches. IDLE afterwards.
- do NI=1,K=2, with a double-cycle body (fetch low on alternate cen): word issued twice; pointers frozen on fetch=0 cycles.
- do NI=2,K=1 (and K=0): body executes once from ROM; cache_sel never asserts; returns to IDLE after 2 fetches.
- After the first test, redo K=3 (do_data=11'h003): A,B,C ×3 from cache with no ROM fetch. With the macro undefined: do_err pulses once, no replay.
- Redo immediately after reset: do_err pulse, state IDLE, cache_sel=0.
- Mid-REPLAY: a second do_start gives a do_err pulse and the loop finishes correctly. Asserting rst mid-REPLAY clears cache_sel, pc_hold and no_int asynchronously.

Source files
------------

// File: rtl/jtdsp16_do_cache.sv
// DO-loop instruction cache: records the first pass of a loop body fetched from ROM
// and replays it for the remaining passes. Define JTDSP16_REDO_EN to enable redo (NI=0).
module jtdsp16_do_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        fetch,
    input  logic        do_start,
    input  logic [10:0] do_data,
    input  logic [15:0] rom_dout,
    output logic [15:0] cache_dout,
    output logic        cache_sel,
    output logic        pc_hold,
    output logic        no_int,
    output logic        do_err,
    output logic [6:0]  loop_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_REPLAY} state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_ni, w_ni_next;
    logic [3:0]  r_wr_ptr, w_wr_ptr_next;
    logic [3:0]  r_rd_ptr, w_rd_ptr_next;
    logic [6:0]  r_iter, w_iter_next;
    logic        r_cache_sel, r_no_int, r_do_err;
    logic        w_do_err_next;
    logic [15:0] r_store [0:14];

    logic [3:0]  w_req_ni;
    logic [6:0]  w_req_k;
    logic [6:0]  w_keff;
    logic [3:0]  w_last_idx;

`ifdef JTDSP16_REDO_EN
    logic [3:0]  r_last_ni, w_last_ni_next;
`endif

    assign w_req_ni   = do_data[10:7];
    assign w_req_k    = do_data[6:0];
    assign w_keff     = (w_req_k < 7'd2) ? 7'd1 : w_req_k;
    assign w_last_idx = r_ni - 4'd1;

    always_comb begin
        w_state_next  = r_state;
        w_ni_next     = r_ni;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_iter_next   = r_iter;
        w_do_err_next = 1'b0;
`ifdef JTDSP16_REDO_EN
        w_last_ni_next = r_last_ni;
`endif
        if (cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (do_start) begin
                        if (w_req_ni != 4'd0) begin
                            w_ni_next     = w_req_ni;
                            w_wr_ptr_next = 4'd0;
                            w_iter_next   = w_keff;
                            w_state_next  = ST_FILL;
`ifdef JTDSP16_REDO_EN
                            w_last_ni_next = w_req_ni;
`endif
                        end else begin
`ifdef JTDSP16_REDO_EN
                            if (r_last_ni != 4'd0) begin
                                w_ni_next     = r_last_ni;
                                w_rd_ptr_next = 4'd0;
                                w_iter_next   = w_keff;
                                w_state_next  = ST_REPLAY;
                            end else begin
                                w_do_err_next = 1'b1;
                            end
`else
                            w_do_err_next = 1'b1;
`endif
                        end
                    end
                end
                ST_FILL: begin
                    w_do_err_next = do_start;
                    if (fetch) begin
                        w_wr_ptr_next = r_wr_ptr + 4'd1;
                        if (r_wr_ptr == w_last_idx) begin
                            if (r_iter >= 7'd2) begin
                                w_iter_next   = r_iter - 7'd1;
                                w_rd_ptr_next = 4'd0;
                                w_state_next  = ST_REPLAY;
                            end else begin
                                // loop_cnt reads as remaining passes, so 0 once finished
                                w_iter_next  = 7'd0;
                                w_state_next = ST_IDLE;
                            end
                        end
                    end
                end
                ST_REPLAY: begin
                    w_do_err_next = do_start;
                    if (fetch) begin
                        if (r_rd_ptr == w_last_idx) begin
                            w_rd_ptr_next = 4'd0;
                            if (r_iter == 7'd1) begin
                                w_iter_next  = 7'd0;
                                w_state_next = ST_IDLE;
                            end else begin
                                w_iter_next = r_iter - 7'd1;
                            end
                        end else begin
                            w_rd_ptr_next = r_rd_ptr + 4'd1;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ni        <= 4'd0;
            r_wr_ptr    <= 4'd0;
            r_rd_ptr    <= 4'd0;
            r_iter      <= 7'd0;
            r_cache_sel <= 1'b0;
            r_no_int    <= 1'b0;
            r_do_err    <= 1'b0;
`ifdef JTDSP16_REDO_EN
            r_last_ni   <= 4'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_ni        <= w_ni_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_iter      <= w_iter_next;
            // Flags track the next state so they line up with it, glitch-free
            r_cache_sel <= (w_state_next == ST_REPLAY);
            r_no_int    <= (w_state_next != ST_IDLE);
            if (cen) begin
                r_do_err <= w_do_err_next;
            end
`ifdef JTDSP16_REDO_EN
            r_last_ni   <= w_last_ni_next;
`endif
        end
    end

    // Body store has no reset; contents persist across loops for redo
    always_ff @(posedge clk) begin
        if (cen && fetch && (r_state == ST_FILL)) begin
            r_store[r_wr_ptr] <= rom_dout;
        end
    end

    assign cache_dout = r_store[r_rd_ptr];
    assign cache_sel  = r_cache_sel;
    assign pc_hold    = r_cache_sel;
    assign no_int     = r_no_int;
    assign do_err     = r_do_err;
    assign loop_cnt   = r_iter;

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Scoreboard bench for jtdsp16_do_cache: a ROM/PC model feeds the cache and every
// decoder fetch is matched against the expected instruction stream.
module tb_jtdsp16_do_cache;
    logic        clk = 1'b0;
    logic        rst, cen, fetch, do_start;
    logic [10:0] do_data;
    logic [15:0] rom_dout, cache_dout;
    logic        cache_sel, pc_hold, no_int, do_err;
    logic [6:0]  loop_cnt;

    always #5 clk = ~clk;

    jtdsp16_do_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .fetch      (fetch),
        .do_start   (do_start),
        .do_data    (do_data),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .cache_sel  (cache_sel),
        .pc_hold    (pc_hold),
        .no_int     (no_int),
        .do_err     (do_err),
        .loop_cnt   (loop_cnt)
    );

    typedef struct packed {
        logic [15:0] word;
        logic [6:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rom [0:63];
    logic [5:0]  pc;
    logic [15:0] fill_words [0:14];
    int          last_ni_model;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_hold, n_int, n_sel;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One instruction-rate cycle: drive at negedge, score the fetch before the edge,
    // return just after the edge so registered outputs can be checked.
    task automatic cyc(input logic c, input logic f, input logic ds, input logic [10:0] dd);
        exp_t        e;
        logic [15:0] w;
        @(negedge clk);
        cen      = c;
        fetch    = f;
        do_start = ds;
        do_data  = dd;
        rom_dout = rom[pc];
        #1;
        if (c && f) begin
            w = cache_sel ? cache_dout : rom_dout;
            if (pc_hold)   n_hold++;
            if (no_int)    n_int++;
            if (cache_sel) n_sel++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("fetch word=%h loop_cnt=%0d from_cache=%0d", w, loop_cnt, cache_sel);
                check_val("word", w, e.word);
                check_val("loop_cnt", loop_cnt, e.cnt);
            end
            if (!pc_hold) pc = pc + 6'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: fetch every cycle, 1: fetch low on alternate cycles, 2: cen low on alternate cycles
    task automatic do_loop(input int ni, input int k, input int mode, input int nest_at);
        int         keff, eff_ni, guard, idx, exp_hold;
        logic       err, redo;
        logic [5:0] base_pc;
        exp_t       e;
        redo = (ni == 0);
        keff = (k < 2) ? 1 : k;
`ifdef JTDSP16_REDO_EN
        err = redo && (last_ni_model == 0);
`else
        err = redo;
`endif
        if (!redo) begin
            for (int i = 0; i < ni; i++) fill_words[i] = rom[6'(int'(pc) + i)];
            last_ni_model = ni;
        end
        eff_ni = redo ? last_ni_model : ni;
        if (!err) begin
            for (int p = 0; p < keff; p++) begin
                for (int i = 0; i < eff_ni; i++) begin
                    e.word = fill_words[i];
                    e.cnt  = 7'(keff - p);
                    exp_q.push_back(e);
                end
            end
        end
        exp_hold = err ? 0 : (redo ? eff_ni * keff : eff_ni * (keff - 1));
        n_hold = 0;
        n_int  = 0;
        n_sel  = 0;
        cyc(1'b1, 1'b0, 1'b1, {4'(ni), 7'(k)});
        check_val("do_err", do_err, err);
        check_val("no_int_start", no_int, !err);
        check_val("cache_sel_start", cache_sel, redo && !err);
        base_pc = pc;
        guard = 0;
        idx = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            cyc(1'b1, 1'b1, (idx == nest_at), 11'h183);
            if (nest_at >= 0 && idx == nest_at) check_val("nest_err", do_err, 1);
            if (mode == 1) cyc(1'b1, 1'b0, 1'b0, 11'h0);
            else if (mode == 2) cyc(1'b0, 1'b1, 1'b0, 11'h0);
            guard++;
            idx++;
        end
        check_val("no_timeout", (guard < 400), 1);
        check_val("end_no_int", no_int, 0);
        check_val("end_cache_sel", cache_sel, 0);
        check_val("end_pc_hold", pc_hold, 0);
        check_val("hold_fetches", n_hold, exp_hold);
        check_val("sel_fetches", n_sel, exp_hold);
        check_val("no_int_fetches", n_int, err ? 0 : eff_ni * keff);
        check_val("pc_advance", 6'(pc - base_pc), (redo || err) ? 0 : eff_ni);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        pc = 6'd0;
        last_ni_model = 0;
        rst = 1'b1;
        cen = 1'b0;
        fetch = 1'b0;
        do_start = 1'b0;
        do_data = 11'h0;
        rom_dout = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cache_sel", cache_sel, 0);
        check_val("rst_pc_hold", pc_hold, 0);
        check_val("rst_no_int", no_int, 0);
        check_val("rst_do_err", do_err, 0);
        check_val("rst_loop_cnt", loop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        do_loop(0, 3, 0, -1);   // redo straight after reset
        do_loop(3, 4, 0, -1);   // A,B,C then x3 from cache
        do_loop(0, 3, 0, -1);   // redo of the stored body
        do_loop(1, 2, 1, -1);   // single-word double-cycle body
        do_loop(2, 1, 2, -1);   // single pass with cen gaps
        do_loop(2, 0, 0, -1);   // K=0 also single pass
        do_loop(2, 3, 0, 3);    // nested do_start during replay
        do_loop(15, 2, 0, -1);  // full depth

        // Asynchronous reset in the middle of a replay
        cyc(1'b1, 1'b0, 1'b1, {4'd2, 7'd5});
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 11'h0);
        check_val("mid_cache_sel", cache_sel, 1);
        check_val("mid_loop_cnt", loop_cnt, 4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_cache_sel", cache_sel, 0);
        check_val("arst_pc_hold", pc_hold, 0);
        check_val("arst_no_int", no_int, 0);
        check_val("arst_loop_cnt", loop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        last_ni_model = 0;
        do_loop(0, 3, 0, -1);   // redo after reset must be rejected

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
